// File: rtl/divider_32bit_seq.sv
// Iterative unsigned restoring divider: Q = A / B, R = A % B, one quotient bit
// per cycle, valid/ready on both sides, one operation in flight.

module divider_32bit_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);
  logic [WIDTH:0] srem;
  logic [WIDTH:0] diff;

  // Trial subtract as add of ~dvs with carry-in; one extra bit so a divisor
  // with its MSB set cannot overflow. diff[WIDTH] is the borrow.
  assign srem = {rem, quo[WIDTH-1]};
  assign diff = srem + {1'b1, ~dvs} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    rem_nxt = srem[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_nxt    = diff[WIDTH-1:0];
      quo_nxt[0] = 1'b1;
    end
  end
endmodule

module divider_32bit_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DivZero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic [WIDTH-1:0] q_r, r_r;
  logic             dz_r;
  logic             last;

  divider_32bit_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign last      = (cnt == CNT_W'(1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Q         = q_r;
  assign R         = r_r;
  assign DivZero   = dz_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (B == '0) ? DONE : RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results live in separate registers so they stay put through RUN and IDLE
  // while the working quo/rem registers iterate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dz_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          quo  <= A;
          dvs  <= B;
          rem  <= '0;
          cnt  <= CNT_W'(WIDTH);
          dz_r <= 1'b0;
          if (B == '0) begin
            q_r  <= '1;
            r_r  <= A;
            dz_r <= 1'b1;
          end
        end
        RUN: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            q_r <= quo_nxt;
            r_r <= rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_32bit_seq.sv
// Scoreboard bench for divider_32bit_seq: directed corner cases plus random
// operands with output stalls, checked against plain / and % arithmetic.

module tb_divider_32bit_seq;
  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Q;
  logic [31:0] R;
  logic        DivZero;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  int   n_drop   = 0;
  bit   force_lo = 1'b0;
  bit   stall    = 1'b0;

  divider_32bit_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .DivZero   (DivZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Output ready: forced low, random stalls, or always ready.
  always @(posedge clk) begin
    #1;
    if (force_lo) out_ready = 1'b0;
    else if (stall) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
  end

  // Monitor: every handoff pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL extra_result: got Q=0x%08h R=0x%08h with nothing expected", Q, R);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        check("Q", Q, e.q);
        check("R", R, e.r);
        check("DivZero", {31'd0, DivZero}, {31'd0, e.dz});
      end
    end
  end

  // Called at a negedge; returns just after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int tries = 0;
    in_valid = 1'b1; A = a; B = b;
    while (!in_ready) begin
      @(negedge clk);
      tries++;
      if (tries > 500) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout: in_ready=0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(model(a, b));
    n_push++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom;
  endtask

  // Counts negedges after the accept edge until out_valid; in_ready must stay low.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    end while (!out_valid && n < 100);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input int lat);
    int n;
    @(negedge clk);
    send(a, b);
    wait_valid(n);
    check("latency", n, lat);
    drain();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_Q", Q, 32'd0);
    check("rst_R", R, 32'd0);
    check("rst_DivZero", {31'd0, DivZero}, 32'd0);
    rst_n = 1'b1;

    directed(32'd100, 32'd7, 33);
    directed(32'hFFFF_FFFF, 32'd1, 33);
    directed(32'hFFFF_FFFF, 32'h8000_0000, 33);
    directed(32'd5, 32'd9, 33);
    directed(32'h1234_5678, 32'h1234_5678, 33);
    directed(32'hDEAD_BEEF, 32'd0, 1);
    directed(32'd10, 32'd3, 33);

    // Backpressure: result held 20 cycles, new operands must be ignored.
    force_lo = 1'b1;
    @(negedge clk);
    send(32'd1000, 32'd10);
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_Q", Q, 32'd100);
      check("hold_R", R, 32'd0);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = i[0]; A = 32'd77; B = 32'd7;
      @(negedge clk);
    end
    force_lo = 1'b0;
    send(32'd77, 32'd7);
    drain();

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    send(32'd50000, 32'd3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    n_drop += sb.size();
    sb.delete();
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_Q", Q, 32'd0);
    check("midrst_R", R, 32'd0);
    rst_n = 1'b1;
    directed(32'd50000, 32'd3, 33);

    // Random operands with random output stalls.
    stall = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 255);
        3:       b = a;
        4:       b = 32'h8000_0000 | $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      @(negedge clk);
      send(a, b);
    end
    drain();

    check("result_count", n_pop, n_push - n_drop);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
